// File: rtl/mem_access_pkg.sv
// Shared types for the MEM-stage load/store engine: funct3 codes, FSM states,
// access-size decode and the registered data-bus request.
package mem_access_pkg;

  localparam int REG_W  = 32;
  localparam int REG_AW = 5;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_BUSY = 2'd1,
    MEM_DONE = 2'd2
  } mem_state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } mem_size_e;

  typedef struct packed {
    logic             we;
    logic [REG_W-1:0] addr;
    logic [3:0]       be;
    logic [REG_W-1:0] wdata;
  } dbus_req_t;

  // Undefined funct3 encodings fall back to word accesses.
  function automatic mem_size_e size_of(input logic [2:0] f3);
    case (f3)
      MEM_B, MEM_BU: size_of = SZ_B;
      MEM_H, MEM_HU: size_of = SZ_H;
      default:       size_of = SZ_W;
    endcase
  endfunction

  function automatic logic is_unsigned(input logic [2:0] f3);
    is_unsigned = (f3 == MEM_BU) || (f3 == MEM_HU);
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (size_of(f3))
      SZ_B:    misaligned = 1'b0;
      SZ_H:    misaligned = a[0];
      default: misaligned = (a != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering for stores and lane extraction with sign/zero extension
// for loads. Purely combinational.
module mem_align
  import mem_access_pkg::*;
(
  input  logic [2:0]       funct3_i,
  input  logic [1:0]       a_i,
  input  logic [REG_W-1:0] sdata_i,
  input  logic [REG_W-1:0] rdata_i,
  output logic [3:0]       be_o,
  output logic [REG_W-1:0] wdata_o,
  output logic [REG_W-1:0] ldata_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic        uns;

  always_comb begin
    byte_v  = rdata_i[{a_i, 3'b000} +: 8];
    half_v  = a_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    uns     = is_unsigned(funct3_i);
    be_o    = 4'b1111;
    wdata_o = sdata_i;
    ldata_o = rdata_i;
    // Halfwords only look at a[1] and words ignore a entirely, so stray low
    // address bits never push lanes off the word.
    case (size_of(funct3_i))
      SZ_B: begin
        be_o    = 4'b0001 << a_i;
        wdata_o = {4{sdata_i[7:0]}};
        ldata_o = uns ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
      end
      SZ_H: begin
        be_o    = 4'b0011 << {a_i[1], 1'b0};
        wdata_o = {2{sdata_i[15:0]}};
        ldata_o = uns ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM-stage load/store engine: pass-through for ALU ops, req/ack data-bus
// access with stall and timeout for ld/st. `MISALIGN_TRAP_EN traps misaligned
// H/W accesses instead of issuing them.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] mem_waddr_i,
  input  logic              mem_we_i,
  input  logic [REG_W-1:0]  mem_wdata_i,
  input  logic              mem_ld_i,
  input  logic              mem_st_i,
  input  logic [2:0]        mem_funct3_i,
  input  logic [REG_W-1:0]  mem_sdata_i,
  output logic              dbus_req_o,
  output logic              dbus_we_o,
  output logic [REG_W-1:0]  dbus_addr_o,
  output logic [3:0]        dbus_be_o,
  output logic [REG_W-1:0]  dbus_wdata_o,
  input  logic              dbus_ack_i,
  input  logic [REG_W-1:0]  dbus_rdata_i,
  output logic              stall_o,
  output logic              err_o,
  output logic [REG_AW-1:0] wb_waddr_o,
  output logic              wb_we_o,
  output logic [REG_W-1:0]  wb_wdata_o
);

  mem_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             req_q;
  dbus_req_t        bus_q;
  logic [2:0]       f3_q;
  logic [1:0]       a_q;
  logic             ld_q;
  logic             ok_q;
  logic             err_q;
  logic [REG_W-1:0] result_q;

  logic             access;
  logic             mis;
  logic             issue;
  logic             timeout_hit;
  logic [2:0]       al_f3;
  logic [1:0]       al_a;
  logic [3:0]       al_be;
  logic [REG_W-1:0] al_wdata;
  logic [REG_W-1:0] al_ldata;

  assign access = mem_ld_i | mem_st_i;

`ifdef MISALIGN_TRAP_EN
  assign mis = access && misaligned(mem_funct3_i, mem_wdata_i[1:0]);
`else
  assign mis = 1'b0;
`endif

  assign issue       = (state_q == MEM_IDLE) && access && !mis;
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

  // Steer from the live inputs while issuing; extract with the latched
  // access shape while waiting for the ack.
  assign al_f3 = (state_q == MEM_IDLE) ? mem_funct3_i : f3_q;
  assign al_a  = (state_q == MEM_IDLE) ? mem_wdata_i[1:0] : a_q;

  mem_align u_align (
    .funct3_i (al_f3),
    .a_i      (al_a),
    .sdata_i  (mem_sdata_i),
    .rdata_i  (dbus_rdata_i),
    .be_o     (al_be),
    .wdata_o  (al_wdata),
    .ldata_o  (al_ldata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= MEM_IDLE;
      cnt_q    <= '0;
      req_q    <= 1'b0;
      bus_q    <= '0;
      f3_q     <= '0;
      a_q      <= '0;
      ld_q     <= 1'b0;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        MEM_IDLE: begin
          if (issue) begin
            req_q       <= 1'b1;
            bus_q.we    <= mem_st_i;
            bus_q.addr  <= {mem_wdata_i[REG_W-1:2], 2'b00};
            bus_q.be    <= al_be;
            bus_q.wdata <= al_wdata;
            f3_q        <= mem_funct3_i;
            a_q         <= mem_wdata_i[1:0];
            ld_q        <= mem_ld_i;
            cnt_q       <= '0;
            state_q     <= MEM_BUSY;
          end
        end
        MEM_BUSY: begin
          cnt_q <= cnt_q + CNT_W'(1);
          // Ack is tested first so a last-cycle ack still completes cleanly.
          if (dbus_ack_i) begin
            req_q    <= 1'b0;
            result_q <= al_ldata;
            ok_q     <= 1'b1;
            state_q  <= MEM_DONE;
          end else if (timeout_hit) begin
            req_q   <= 1'b0;
            err_q   <= 1'b1;
            ok_q    <= 1'b0;
            state_q <= MEM_DONE;
          end
        end
        MEM_DONE: state_q <= MEM_IDLE;
        default:  state_q <= MEM_IDLE;
      endcase
    end
  end

  assign dbus_req_o   = req_q;
  assign dbus_we_o    = bus_q.we;
  assign dbus_addr_o  = bus_q.addr;
  assign dbus_be_o    = bus_q.be;
  assign dbus_wdata_o = bus_q.wdata;

  assign stall_o = !rst && (issue || (state_q == MEM_BUSY));
  assign err_o   = !rst && (err_q || ((state_q == MEM_IDLE) && mis));

  always_comb begin
    wb_waddr_o = mem_waddr_i;
    wb_we_o    = mem_we_i;
    wb_wdata_o = mem_wdata_i;
    if (rst) begin
      wb_waddr_o = '0;
      wb_we_o    = 1'b0;
      wb_wdata_o = '0;
    end else begin
      case (state_q)
        MEM_IDLE: if (access) wb_we_o = 1'b0;
        MEM_BUSY: wb_we_o = 1'b0;
        MEM_DONE: begin
          wb_we_o    = ld_q && ok_q;
          wb_wdata_o = result_q;
        end
        default: wb_we_o = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: a scoreboard of expected writeback
// results, a bus responder with programmable ack delay, one task per scenario.
module tb_mem_access;
  import mem_access_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  mem_waddr_i;
  logic        mem_we_i;
  logic [31:0] mem_wdata_i;
  logic        mem_ld_i;
  logic        mem_st_i;
  logic [2:0]  mem_funct3_i;
  logic [31:0] mem_sdata_i;
  logic        dbus_req_o;
  logic        dbus_we_o;
  logic [31:0] dbus_addr_o;
  logic [3:0]  dbus_be_o;
  logic [31:0] dbus_wdata_o;
  logic        dbus_ack_i;
  logic [31:0] dbus_rdata_i;
  logic        stall_o;
  logic        err_o;
  logic [4:0]  wb_waddr_o;
  logic        wb_we_o;
  logic [31:0] wb_wdata_o;

  mem_access #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .mem_waddr_i(mem_waddr_i), .mem_we_i(mem_we_i), .mem_wdata_i(mem_wdata_i),
    .mem_ld_i(mem_ld_i), .mem_st_i(mem_st_i), .mem_funct3_i(mem_funct3_i),
    .mem_sdata_i(mem_sdata_i),
    .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
    .dbus_be_o(dbus_be_o), .dbus_wdata_o(dbus_wdata_o),
    .dbus_ack_i(dbus_ack_i), .dbus_rdata_i(dbus_rdata_i),
    .stall_o(stall_o), .err_o(err_o),
    .wb_waddr_o(wb_waddr_o), .wb_we_o(wb_we_o), .wb_wdata_o(wb_wdata_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } wb_t;

  wb_t exp_q[$];
  int  errors = 0;
  int  checks = 0;

  // Observations of the most recent access.
  logic [31:0] o_addr, o_wdata;
  logic [3:0]  o_be;
  logic        o_we, o_done;
  int          o_req_n, o_stall_n, o_err_n;
  wb_t         o_wb;

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] a,
                                           input logic [31:0] rd);
    logic [31:0] s;
    case (f3)
      3'b000, 3'b100: begin
        s = (rd >> (a * 8)) & 32'hFF;
        if (f3 == 3'b000 && s[7]) s = s | 32'hFFFF_FF00;
      end
      3'b001, 3'b101: begin
        s = (rd >> (a[1] ? 16 : 0)) & 32'hFFFF;
        if (f3 == 3'b001 && s[15]) s = s | 32'hFFFF_0000;
      end
      default: s = rd;
    endcase
    return s;
  endfunction

  task automatic drive_nop;
    mem_ld_i = 0; mem_st_i = 0; mem_we_i = 0; mem_waddr_i = 0;
    mem_wdata_i = 0; mem_funct3_i = 0; mem_sdata_i = 0;
  endtask

  // Drives one ld/st and acts as the memory: ack in BUSY cycle ack_at
  // (0 = never). Returns after sampling the first non-stalled cycle.
  task automatic run_access(input logic ld, input logic st, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] sdata,
                            input logic [4:0] waddr, input int ack_at,
                            input logic [31:0] rdata);
    o_req_n = 0; o_stall_n = 0; o_err_n = 0; o_done = 0;
    o_addr = 0; o_be = 0; o_wdata = 0; o_we = 0;
    o_wb.we = 0; o_wb.waddr = 0; o_wb.wdata = 0;
    @(negedge clk);
    mem_ld_i = ld; mem_st_i = st; mem_we_i = ld; mem_funct3_i = f3;
    mem_wdata_i = addr; mem_sdata_i = sdata; mem_waddr_i = waddr;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (err_o) o_err_n++;
      if (!stall_o) begin
        o_wb.we = wb_we_o; o_wb.waddr = wb_waddr_o; o_wb.wdata = wb_wdata_o;
        o_done = 1;
        dbus_ack_i = 0;
        break;
      end
      o_stall_n++;
      if (dbus_req_o) begin
        o_req_n++;
        if (o_req_n == 1) begin
          o_addr = dbus_addr_o; o_be = dbus_be_o; o_wdata = dbus_wdata_o; o_we = dbus_we_o;
        end
      end
      dbus_ack_i   = dbus_req_o && (o_req_n == ack_at);
      dbus_rdata_i = dbus_ack_i ? rdata : 32'h0;
    end
  endtask

  task automatic test_reset;
    rst = 1;
    mem_we_i = 1; mem_waddr_i = 5'd7; mem_wdata_i = 32'hDEAD_BEEF; mem_ld_i = 1;
    @(negedge clk); @(negedge clk); #1;
    checks++; if (wb_we_o !== 1'b0) begin errors++; $display("FAIL rst_wb_we got=%b exp=0", wb_we_o); end
    checks++; if (wb_wdata_o !== 32'h0) begin errors++; $display("FAIL rst_wb_wdata got=%h exp=0", wb_wdata_o); end
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL rst_stall got=%b exp=0", stall_o); end
    checks++; if (dbus_req_o !== 1'b0) begin errors++; $display("FAIL rst_req got=%b exp=0", dbus_req_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL rst_err got=%b exp=0", err_o); end
    @(negedge clk);
    rst = 0;
    drive_nop();
  endtask

  task automatic test_alu_pass;
    @(negedge clk);
    mem_we_i = 1; mem_waddr_i = 5'd5; mem_wdata_i = 32'h1234;
    #1;
    checks++; if (wb_we_o !== 1'b1) begin errors++; $display("FAIL alu_we got=%b exp=1", wb_we_o); end
    checks++; if (wb_waddr_o !== 5'd5) begin errors++; $display("FAIL alu_waddr got=%0d exp=5", wb_waddr_o); end
    checks++; if (wb_wdata_o !== 32'h1234) begin errors++; $display("FAIL alu_wdata got=%h exp=1234", wb_wdata_o); end
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL alu_stall got=%b exp=0", stall_o); end
    @(negedge clk);
    mem_we_i = 0; mem_waddr_i = 5'd31; mem_wdata_i = 32'hFFFF_FFFF;
    #1;
    checks++; if (wb_we_o !== 1'b0 || wb_wdata_o !== 32'hFFFF_FFFF)
      begin errors++; $display("FAIL alu_nowe got=%b/%h exp=0/ffffffff", wb_we_o, wb_wdata_o); end
    drive_nop();
  endtask

  task automatic test_lb;
    wb_t e;
    exp_q.push_back('{1'b1, 5'd3, 32'hFFFF_FF80});
    run_access(1, 0, MEM_B, 32'h103, 32'h0, 5'd3, 2, 32'h80FF_FF00);
    checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL lb_done got=%b exp=1", o_done); end
    checks++; if (o_be !== 4'b1000) begin errors++; $display("FAIL lb_be got=%b exp=1000", o_be); end
    checks++; if (o_addr !== 32'h100) begin errors++; $display("FAIL lb_addr got=%h exp=100", o_addr); end
    checks++; if (o_we !== 1'b0) begin errors++; $display("FAIL lb_dbus_we got=%b exp=0", o_we); end
    checks++; if (o_stall_n != 3) begin errors++; $display("FAIL lb_stall_cycles got=%0d exp=3", o_stall_n); end
    checks++; if (o_err_n != 0) begin errors++; $display("FAIL lb_err got=%0d exp=0", o_err_n); end
    e = exp_q.pop_front();
    checks++; if (o_wb.we !== e.we || o_wb.waddr !== e.waddr || o_wb.wdata !== e.wdata)
      begin errors++; $display("FAIL lb_wb got=%b/%0d/%h exp=%b/%0d/%h", o_wb.we, o_wb.waddr, o_wb.wdata, e.we, e.waddr, e.wdata); end
    drive_nop();
  endtask

  task automatic test_store;
    wb_t e;
    exp_q.push_back('{1'b0, 5'd4, 32'h0});
    run_access(0, 1, MEM_H, 32'h202, 32'hABCD_1234, 5'd4, 1, 32'h0);
    checks++; if (o_addr !== 32'h200) begin errors++; $display("FAIL sh_addr got=%h exp=200", o_addr); end
    checks++; if (o_be !== 4'b1100) begin errors++; $display("FAIL sh_be got=%b exp=1100", o_be); end
    checks++; if (o_wdata !== 32'h1234_1234) begin errors++; $display("FAIL sh_wdata got=%h exp=12341234", o_wdata); end
    checks++; if (o_we !== 1'b1) begin errors++; $display("FAIL sh_dbus_we got=%b exp=1", o_we); end
    checks++; if (o_stall_n != 2) begin errors++; $display("FAIL sh_stall_cycles got=%0d exp=2", o_stall_n); end
    e = exp_q.pop_front();
    checks++; if (o_wb.we !== e.we || o_wb.waddr !== e.waddr)
      begin errors++; $display("FAIL sh_wb got=%b/%0d exp=%b/%0d", o_wb.we, o_wb.waddr, e.we, e.waddr); end
    exp_q.push_back('{1'b0, 5'd9, 32'h0});
    run_access(0, 1, MEM_B, 32'h201, 32'h0000_77A5, 5'd9, 3, 32'h0);
    checks++; if (o_be !== 4'b0010 || o_wdata !== 32'hA5A5_A5A5)
      begin errors++; $display("FAIL sb_lanes got=%b/%h exp=0010/a5a5a5a5", o_be, o_wdata); end
    e = exp_q.pop_front();
    checks++; if (o_wb.we !== e.we) begin errors++; $display("FAIL sb_wb_we got=%b exp=%b", o_wb.we, e.we); end
    drive_nop();
  endtask

  task automatic test_timeout;
    wb_t e;
    exp_q.push_back('{1'b0, 5'd6, 32'h0});
    run_access(1, 0, MEM_W, 32'h400, 32'h0, 5'd6, 0, 32'h0);
    checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL to_done got=%b exp=1", o_done); end
    checks++; if (o_req_n != 16) begin errors++; $display("FAIL to_req_cycles got=%0d exp=16", o_req_n); end
    checks++; if (o_err_n != 1) begin errors++; $display("FAIL to_err_cycles got=%0d exp=1", o_err_n); end
    e = exp_q.pop_front();
    checks++; if (o_wb.we !== e.we || o_wb.waddr !== e.waddr)
      begin errors++; $display("FAIL to_wb got=%b/%0d exp=%b/%0d", o_wb.we, o_wb.waddr, e.we, e.waddr); end
    drive_nop();
    @(negedge clk); #1;
    checks++; if (err_o !== 1'b0 || stall_o !== 1'b0 || dbus_req_o !== 1'b0)
      begin errors++; $display("FAIL to_idle got=err%b/stall%b/req%b exp=0/0/0", err_o, stall_o, dbus_req_o); end
  endtask

  task automatic test_misalign;
    wb_t e;
`ifdef MISALIGN_TRAP_EN
    exp_q.push_back('{1'b0, 5'd8, 32'h0});
    run_access(1, 0, MEM_W, 32'h101, 32'h0, 5'd8, 1, 32'h1122_3344);
    checks++; if (o_req_n != 0) begin errors++; $display("FAIL mis_req got=%0d exp=0", o_req_n); end
    checks++; if (o_err_n != 1) begin errors++; $display("FAIL mis_err got=%0d exp=1", o_err_n); end
    checks++; if (o_stall_n != 0) begin errors++; $display("FAIL mis_stall got=%0d exp=0", o_stall_n); end
    e = exp_q.pop_front();
    checks++; if (o_wb.we !== e.we) begin errors++; $display("FAIL mis_wb_we got=%b exp=%b", o_wb.we, e.we); end
`else
    exp_q.push_back('{1'b1, 5'd8, 32'h1122_3344});
    run_access(1, 0, MEM_W, 32'h101, 32'h0, 5'd8, 1, 32'h1122_3344);
    checks++; if (o_addr !== 32'h100) begin errors++; $display("FAIL lw_addr got=%h exp=100", o_addr); end
    checks++; if (o_be !== 4'b1111) begin errors++; $display("FAIL lw_be got=%b exp=1111", o_be); end
    checks++; if (o_err_n != 0) begin errors++; $display("FAIL lw_err got=%0d exp=0", o_err_n); end
    e = exp_q.pop_front();
    checks++; if (o_wb.we !== e.we || o_wb.wdata !== e.wdata)
      begin errors++; $display("FAIL lw_wb got=%b/%h exp=%b/%h", o_wb.we, o_wb.wdata, e.we, e.wdata); end
`endif
    drive_nop();
  endtask

  task automatic test_back_to_back;
    logic [2:0]  f3s   [8] = '{3'b100, 3'b000, 3'b001, 3'b101, 3'b001, 3'b010, 3'b011, 3'b000};
    logic [31:0] addrs [8] = '{32'h001, 32'h002, 32'h002, 32'h006, 32'h000, 32'h008, 32'h00C, 32'h000};
    logic [31:0] rds   [8] = '{32'h1234_F600, 32'hA57F_1122, 32'h8001_7FFF, 32'h8001_7FFF,
                               32'h8001_7FFF, 32'hCAFE_BABE, 32'h0BAD_F00D, 32'h0000_00FF};
    wb_t e;
    int  d;
    for (int i = 0; i < 8; i++) begin
      d = $urandom_range(1, 3);
      exp_q.push_back('{1'b1, 5'(i + 10), ref_load(f3s[i], addrs[i][1:0], rds[i])});
      run_access(1, 0, f3s[i], addrs[i], 32'h0, 5'(i + 10), d, rds[i]);
      checks++; if (o_stall_n != d + 1) begin errors++; $display("FAIL b2b%0d_stall got=%0d exp=%0d", i, o_stall_n, d + 1); end
      e = exp_q.pop_front();
      checks++; if (o_wb.we !== e.we || o_wb.waddr !== e.waddr || o_wb.wdata !== e.wdata)
        begin errors++; $display("FAIL b2b%0d_wb got=%b/%0d/%h exp=%b/%0d/%h", i, o_wb.we, o_wb.waddr, o_wb.wdata, e.we, e.waddr, e.wdata); end
    end
    drive_nop();
  endtask

  task automatic test_rst_mid;
    @(negedge clk);
    mem_ld_i = 1; mem_we_i = 1; mem_funct3_i = MEM_W; mem_wdata_i = 32'h300; mem_waddr_i = 5'd2;
    @(negedge clk); #1;
    checks++; if (dbus_req_o !== 1'b1) begin errors++; $display("FAIL rm_busy_req got=%b exp=1", dbus_req_o); end
    @(negedge clk);
    rst = 1;
    @(negedge clk); #1;
    checks++; if (dbus_req_o !== 1'b0 || stall_o !== 1'b0 || err_o !== 1'b0)
      begin errors++; $display("FAIL rm_reset got=req%b/stall%b/err%b exp=0/0/0", dbus_req_o, stall_o, err_o); end
    rst = 0;
    drive_nop();
    @(negedge clk); #1;
    checks++; if (dbus_req_o !== 1'b0 || stall_o !== 1'b0 || err_o !== 1'b0)
      begin errors++; $display("FAIL rm_after got=req%b/stall%b/err%b exp=0/0/0", dbus_req_o, stall_o, err_o); end
    mem_we_i = 1; mem_waddr_i = 5'd1; mem_wdata_i = 32'h55;
    #1;
    checks++; if (wb_we_o !== 1'b1 || wb_wdata_o !== 32'h55)
      begin errors++; $display("FAIL rm_idle_pass got=%b/%h exp=1/55", wb_we_o, wb_wdata_o); end
    drive_nop();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    dbus_ack_i = 0; dbus_rdata_i = 0;
    drive_nop();
    test_reset();
    test_alu_pass();
    test_lb();
    test_store();
    test_timeout();
    test_misalign();
    test_back_to_back();
    test_rst_mid();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
